permute_result_collector: RTL and testbench
===========================================

# permute_result_collector

Consumer-side endpoint of the full-permutation pipeline's result stream. It accepts the 64-bit per-bot result words (ECC flag, pcoeff count, summed data) under a valid/ready handshake and accumulates them per top. Each top's expected bot count comes from a small job FIFO, and the block emits one aggregated record per top. It sits between the pipeline output and the host-facing result writer, and takes over the result-checking role the simulation bench currently fills.

## Interface
Parameters:
- JOB_FIFO_DEPTH, 4, number of queued top jobs (power of two, ≥2)
- COUNT_WIDTH, 16, width of per-top bot count
- SUM_WIDTH, 64, width of per-top summed-data accumulator (≥48)
- PCOEFF_WIDTH, 32, width of per-top pcoeff-count accumulator (≥13)

Ports:
- clock  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- jobValid  in  1  a top job (bot count) is offered
- jobReady  out  1  job FIFO not full
- jobBotCount  in  COUNT_WIDTH  number of result words belonging to this top
- resultValid  in  1  pipeline result word valid
- resultReady  out  1  collector accepts a result word this cycle
- resultData  in  64  bit 63 ECC error, bits 62:61 reserved (ignored), bits 60:48 pcoeff count, bits 47:0 summed data
- topValid  out  1  aggregated top record valid
- topReady  in  1  downstream accepts the record
- topSum  out  SUM_WIDTH  sum of summed-data fields
- topPcoeff  out  PCOEFF_WIDTH  sum of pcoeff-count fields
- topEcc  out  1  OR of ECC bits over the top
- topOverflow  out  1  either accumulator carried out at least once

## Operation
- Job FIFO: push on jobValid & jobReady; jobReady = (occupancy < JOB_FIFO_DEPTH), from registered occupancy only (no same-cycle pop bypass). Pop only in IDLE.
- FSM states are IDLE, ACCUM and EMIT.
- IDLE: if FIFO non-empty, pop, load remaining ← jobBotCount, clear accumulators/flags. Go to EMIT if the count is 0, otherwise to ACCUM.
- ACCUM: resultReady = 1. On each accept (resultValid & resultReady):
  - sum += zero-extended data[47:0]
  - pcoeff += data[60:48]
  - ecc |= data[63]
  - overflow |= carry-out of either adder
  - remaining −= 1
- Accumulators wrap modulo 2^width.
- When the last word is accepted (remaining was 1), go to EMIT.
- EMIT: topValid = 1 with outputs stable until topValid & topReady, then IDLE.
- resultReady = 0 in IDLE and EMIT; result words arriving then are back-pressured, never dropped.
- Words beyond a top's count are never consumed into that top.

## Timing
- Reset (rst low at an edge): all state cleared next edge. topValid=0, resultReady=0, jobReady=0 while rst low, topSum=topPcoeff=0, topEcc=topOverflow=0. FIFO emptied; FSM→IDLE. Partial accumulation mid-top is discarded. jobReady=1 the first edge after rst goes high.
- Job push to IDLE pop: pop at the edge after the push is visible in occupancy (≥1 cycle). ACCUM is entered on the following edge.
- Throughput: one result word per clock in ACCUM, sustained.
- Latency: topValid rises the edge after the last word is accepted.
- Zero-count job: IDLE→EMIT, record with all-zero outputs one cycle after pop.
- Record-to-next-job bubble: the handshake edge returns to IDLE; the next pop is on the following edge. Minimum 2 idle resultReady cycles between tops.
- Full FIFO with a simultaneous pop: jobReady stays 0 that cycle and reasserts next cycle.
- Outputs are registered; topSum and related outputs change only on an IDLE pop (cleared) or an ACCUM accept.

## Test plan
- Reset: hold rst low 3 cycles mid-ACCUM with 2 of 5 words accepted -> topValid=0, resultReady=0, FIFO empty. After release, a new job of 1 word with data=0x0001_0000_0000_0007 -> topSum=7, topPcoeff=1, topEcc=0.
- Basic top: job 3, words with summed data 10, 20, 30 and pcoeff 1, 2, 3, resultValid continuous -> one accept per cycle. topValid 1 cycle after the 3rd accept: topSum=60, topPcoeff=6, topEcc=0.
- Back-pressure: topReady=0 for 10 cycles after topValid -> record stable and resultReady=0 throughout, next job's words not consumed. Record handed over on the topReady edge.
- ECC and zero job: job counts 2,0,1 queued; first top has bit 63 set on word 2. Records in order: ecc=1 for the first, all zeros for the second, the correct sum for the third.
- FIFO full: push 4 jobs with the FSM blocked in EMIT -> jobReady=0 on the 5th attempt, 5th job not stored. jobReady returns 1 the cycle after a pop.
- Overflow wrap: SUM_WIDTH=48, job 2, data[47:0]=0xFFFF_FFFF_FFFF each -> topSum=0xFFFF_FFFF_FFFE, topOverflow=1.

Source files
------------

// File: rtl/permute_result_collector.sv
// -----------------------------------------------------------------------------
// permute_result_collector
//
// Consumer-side endpoint of the full-permutation result stream. Top jobs
// (expected bot counts) are queued in a small FIFO. For each job, exactly
// that many 64-bit result words are accepted and accumulated. One aggregated
// record is then emitted per top.
//
// Ports:
//   clock        in   rising-edge clock
//   rst          in   synchronous, active-low reset
//   jobValid     in   a top job is offered
//   jobReady     out  job FIFO has room (registered occupancy only)
//   jobBotCount  in   number of result words belonging to the offered top
//   resultValid  in   result word valid
//   resultReady  out  result word accepted this cycle (ACCUM only)
//   resultData   in   [63] ECC error, [62:61] reserved, [60:48] pcoeff count,
//                     [47:0] summed data
//   topValid     out  aggregated record valid (held until topReady)
//   topReady     in   downstream takes the record
//   topSum       out  wrapped sum of summed-data fields
//   topPcoeff    out  wrapped sum of pcoeff-count fields
//   topEcc       out  OR of ECC bits over the top
//   topOverflow  out  either accumulator carried out at least once
// -----------------------------------------------------------------------------
module permute_result_collector #(
   parameter int JOB_FIFO_DEPTH = 4,
   parameter int COUNT_WIDTH    = 16,
   parameter int SUM_WIDTH      = 64,
   parameter int PCOEFF_WIDTH   = 32
) (
   input  logic                    clock,
   input  logic                    rst,
   input  logic                    jobValid,
   output logic                    jobReady,
   input  logic [COUNT_WIDTH-1:0]  jobBotCount,
   input  logic                    resultValid,
   output logic                    resultReady,
   input  logic [63:0]             resultData,
   output logic                    topValid,
   input  logic                    topReady,
   output logic [SUM_WIDTH-1:0]    topSum,
   output logic [PCOEFF_WIDTH-1:0] topPcoeff,
   output logic                    topEcc,
   output logic                    topOverflow
);

   localparam int PTR_W = $clog2(JOB_FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_EMIT
   } state_t;

   state_t r_state;
   state_t w_next_state;

   // Job FIFO
   logic [COUNT_WIDTH-1:0] r_job_mem [JOB_FIFO_DEPTH];
   logic [PTR_W-1:0]       r_wr_ptr;
   logic [PTR_W-1:0]       r_rd_ptr;
   logic [PTR_W:0]         r_occupancy;
   logic [COUNT_WIDTH-1:0] w_head_count;
   logic                   w_fifo_empty;
   logic                   w_push;
   logic                   w_pop;

   // Accumulation datapath
   logic [COUNT_WIDTH-1:0]  r_remaining;
   logic [SUM_WIDTH-1:0]    r_sum;
   logic [PCOEFF_WIDTH-1:0] r_pcoeff;
   logic                    r_ecc;
   logic                    r_overflow;
   logic [SUM_WIDTH:0]      w_sum_ext;
   logic [PCOEFF_WIDTH:0]   w_pcoeff_ext;
   logic                    w_accept;
   logic                    w_result_ready;
   logic                    w_top_valid;

   // Reserved bits 62:61 carry no meaning for this block.
   logic w_unused_reserved;
   assign w_unused_reserved = ^resultData[62:61];

   assign w_fifo_empty = (r_occupancy == '0);
   assign w_head_count = r_job_mem[r_rd_ptr];

   // Handshake outputs are forced low while reset is asserted, independent of
   // whatever the registers held before the first reset edge.
   assign jobReady    = rst && (r_occupancy < (PTR_W+1)'(JOB_FIFO_DEPTH));
   assign resultReady = rst && w_result_ready;
   assign topValid    = rst && w_top_valid;
   assign w_push      = jobValid && jobReady;

   // One extra bit on each adder captures the carry-out for the overflow flag.
   assign w_sum_ext    = {1'b0, r_sum} + (SUM_WIDTH+1)'(resultData[47:0]);
   assign w_pcoeff_ext = {1'b0, r_pcoeff} + (PCOEFF_WIDTH+1)'(resultData[60:48]);

   // -------------------------------------------------------------------------
   // FSM
   // -------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      // NOTE: state elements use non-blocking assignments so every register
      // samples pre-edge values regardless of block evaluation order.
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      // NOTE: every signal driven here is given a default first; a path that
      // left one unassigned would infer a latch.
      w_next_state   = r_state;
      w_pop          = 1'b0;
      w_accept       = 1'b0;
      w_result_ready = 1'b0;
      w_top_valid    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (!w_fifo_empty) begin
               w_pop        = 1'b1;
               w_next_state = (w_head_count == '0) ? S_EMIT : S_ACCUM;
            end
         end
         S_ACCUM: begin
            w_result_ready = 1'b1;
            w_accept       = resultValid;
            if (resultValid && (r_remaining == COUNT_WIDTH'(1))) begin
               w_next_state = S_EMIT;
            end
         end
         S_EMIT: begin
            w_top_valid = 1'b1;
            if (topReady) begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Job FIFO
   // -------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_occupancy <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         unique case ({w_push, w_pop})
            2'b10:   r_occupancy <= r_occupancy + (PTR_W+1)'(1);
            2'b01:   r_occupancy <= r_occupancy - (PTR_W+1)'(1);
            default: r_occupancy <= r_occupancy;
         endcase
      end
   end

   // NOTE: the storage array is deliberately not reset; an entry is only read
   // after it has been written, which the occupancy count guarantees.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_job_mem[r_wr_ptr] <= jobBotCount;
      end
   end

   // -------------------------------------------------------------------------
   // Accumulators: cleared on pop, updated on accept, otherwise held so the
   // record stays stable through EMIT back-pressure.
   // -------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!rst) begin
         r_remaining <= '0;
         r_sum       <= '0;
         r_pcoeff    <= '0;
         r_ecc       <= 1'b0;
         r_overflow  <= 1'b0;
      end else if (w_pop) begin
         r_remaining <= w_head_count;
         r_sum       <= '0;
         r_pcoeff    <= '0;
         r_ecc       <= 1'b0;
         r_overflow  <= 1'b0;
      end else if (w_accept) begin
         r_remaining <= r_remaining - COUNT_WIDTH'(1);
         r_sum       <= w_sum_ext[SUM_WIDTH-1:0];
         r_pcoeff    <= w_pcoeff_ext[PCOEFF_WIDTH-1:0];
         r_ecc       <= r_ecc | resultData[63];
         r_overflow  <= r_overflow | w_sum_ext[SUM_WIDTH] | w_pcoeff_ext[PCOEFF_WIDTH];
      end
   end

   assign topSum      = r_sum;
   assign topPcoeff   = r_pcoeff;
   assign topEcc      = r_ecc;
   assign topOverflow = r_overflow;

endmodule

// File: tb/tb_permute_result_collector.sv
// -----------------------------------------------------------------------------
// tb_permute_result_collector
//
// Directed scenarios followed by randomized traffic. The reference model keeps
// the queue of jobs handed to the block and the ordered list of words it has
// taken; each record is predicted by summing that top's words with plain
// wide arithmetic (wrap = modulo, overflow = true total reached 2^width).
// -----------------------------------------------------------------------------
module tb_permute_result_collector;

   localparam int DEPTH = 4;
   localparam int CW    = 16;
   localparam int SW    = 48;
   localparam int PW    = 13;

   logic          clock = 1'b0;
   logic          rst;
   logic          jobValid;
   logic          jobReady;
   logic [CW-1:0] jobBotCount;
   logic          resultValid;
   logic          resultReady;
   logic [63:0]   resultData;
   logic          topValid;
   logic          topReady;
   logic [SW-1:0] topSum;
   logic [PW-1:0] topPcoeff;
   logic          topEcc;
   logic          topOverflow;

   always #5 clock = ~clock;

   permute_result_collector #(
      .JOB_FIFO_DEPTH (DEPTH),
      .COUNT_WIDTH    (CW),
      .SUM_WIDTH      (SW),
      .PCOEFF_WIDTH   (PW)
   ) dut (
      .clock       (clock),
      .rst         (rst),
      .jobValid    (jobValid),
      .jobReady    (jobReady),
      .jobBotCount (jobBotCount),
      .resultValid (resultValid),
      .resultReady (resultReady),
      .resultData  (resultData),
      .topValid    (topValid),
      .topReady    (topReady),
      .topSum      (topSum),
      .topPcoeff   (topPcoeff),
      .topEcc      (topEcc),
      .topOverflow (topOverflow)
   );

   int n_vec = 0;
   int n_err = 0;
   int n_rec = 0;

   // Stimulus sources
   int          job_q[$];
   logic [63:0] tx_q[$];
   bit          jv_en;
   bit          rv_en;

   // Reference model: jobs inside the block, words it has taken
   int          mq[$];
   logic [63:0] acc_q[$];
   bit          chk_done;

   // Records handed over, indexed by record number
   logic [63:0] rec_sum [64];
   logic [63:0] rec_pc  [64];
   logic        rec_ecc [64];
   logic        rec_ovf [64];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] mk(input logic ecc, input logic [12:0] pc, input logic [47:0] d);
      return {ecc, 2'b00, pc, d};
   endfunction

   function automatic logic [63:0] rand_word();
      logic [63:0] w;
      w     = {$urandom, $urandom};
      w[63] = ($urandom_range(0, 15) == 0);
      return w;
   endfunction

   // One clock cycle: drive inputs, check outputs against the model, advance.
   task automatic step();
      bit              push, acc, hs, in_rst;
      int              head, idx;
      longint unsigned ts, tp;
      logic            e;
      jobValid    = jv_en && (job_q.size() > 0);
      jobBotCount = '0;
      if (jobValid) jobBotCount = CW'(job_q[0]);
      resultValid = rv_en && (tx_q.size() > 0);
      resultData  = '0;
      if (resultValid) resultData = tx_q[0];
      #1;
      in_rst = !rst;
      if (in_rst) begin
         check("rst_topValid", topValid, 0);
         check("rst_resultReady", resultReady, 0);
         check("rst_jobReady", jobReady, 0);
      end else begin
         if (chk_done) check("latency_top", topValid, 1);
         chk_done = 0;
         head = (mq.size() > 0) ? mq[0] : -1;
         if (head < 0 || acc_q.size() >= head) check("ready_low", resultReady, 0);
         else if (acc_q.size() > 0)             check("ready_high", resultReady, 1);
         if (head < 0 || acc_q.size() < head) begin
            check("top_early", topValid, 0);
         end else if (topValid) begin
            ts = 0; tp = 0; e = 1'b0;
            for (int i = 0; i < head; i++) begin
               ts += longint'(acc_q[i][47:0]);
               tp += longint'(acc_q[i][60:48]);
               e  |= acc_q[i][63];
            end
            check("top_sum", topSum, ts & ((64'd1 << SW) - 1));
            check("top_pcoeff", topPcoeff, tp & ((64'd1 << PW) - 1));
            check("top_ecc", topEcc, e);
            check("top_overflow", topOverflow, ((ts >> SW) != 0) || ((tp >> PW) != 0));
         end
      end
      push = jobValid && jobReady;
      acc  = resultValid && resultReady;
      hs   = topValid && topReady;
      if (hs) begin
         idx          = n_rec % 64;
         rec_sum[idx] = 64'(topSum);
         rec_pc[idx]  = 64'(topPcoeff);
         rec_ecc[idx] = topEcc;
         rec_ovf[idx] = topOverflow;
      end
      @(posedge clock);
      #1;
      if (in_rst) begin
         mq.delete();
         acc_q.delete();
         chk_done = 0;
      end else begin
         if (hs) begin
            n_rec++;
            if (mq.size() > 0) begin
               for (int i = 0; i < mq[0]; i++) if (acc_q.size() > 0) void'(acc_q.pop_front());
               void'(mq.pop_front());
            end
         end
         if (push) begin
            mq.push_back(job_q[0]);
            void'(job_q.pop_front());
         end
         if (acc) begin
            acc_q.push_back(tx_q[0]);
            void'(tx_q.pop_front());
            if (mq.size() > 0 && acc_q.size() == mq[0]) chk_done = 1;
         end
      end
   endtask

   task automatic wait_recs(input int n, input int budget);
      int target;
      int k;
      target = n_rec + n;
      k      = 0;
      while (n_rec < target && k < budget) begin
         step();
         k++;
      end
      check("record_wait", n_rec, target);
   endtask

   task automatic wait_top(input int budget);
      int k;
      k = 0;
      while (!topValid && k < budget) begin
         step();
         k++;
      end
      check("top_wait", topValid, 1);
   endtask

   task automatic wait_acc(input int n, input int budget);
      int k;
      k = 0;
      while (acc_q.size() < n && k < budget) begin
         step();
         k++;
      end
      check("accept_wait", acc_q.size(), n);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int b;
      int target;
      int k;
      rst         = 1'b0;
      jobValid    = 1'b0;
      jobBotCount = '0;
      resultValid = 1'b0;
      resultData  = '0;
      topReady    = 1'b0;
      jv_en       = 1'b1;
      rv_en       = 1'b1;
      chk_done    = 0;

      // Reset state
      repeat (3) step();
      check("rst_sum", topSum, 0);
      check("rst_pcoeff", topPcoeff, 0);
      check("rst_ecc", topEcc, 0);
      check("rst_ovf", topOverflow, 0);
      rst = 1'b1;
      #1;
      check("rst_release_jready", jobReady, 1);

      // Reset in the middle of a 5-word top, 2 words in
      topReady = 1'b1;
      job_q.push_back(5);
      repeat (5) tx_q.push_back(rand_word());
      wait_acc(2, 20);
      rst = 1'b0;
      job_q.delete();
      tx_q.delete();
      repeat (3) step();
      check("rst_mid_sum", topSum, 0);
      rst = 1'b1;
      repeat (3) step();
      check("rst_mid_jready", jobReady, 1);
      b = n_rec;
      job_q.push_back(1);
      tx_q.push_back(64'h0001_0000_0000_0007);
      wait_recs(1, 20);
      check("rst_new_sum", rec_sum[b % 64], 7);
      check("rst_new_pcoeff", rec_pc[b % 64], 1);
      check("rst_new_ecc", rec_ecc[b % 64], 0);

      // Basic top of three words
      b = n_rec;
      job_q.push_back(3);
      tx_q.push_back(mk(0, 1, 10));
      tx_q.push_back(mk(0, 2, 20));
      tx_q.push_back(mk(0, 3, 30));
      wait_recs(1, 30);
      check("basic_sum", rec_sum[b % 64], 60);
      check("basic_pcoeff", rec_pc[b % 64], 6);
      check("basic_ecc", rec_ecc[b % 64], 0);
      check("basic_ovf", rec_ovf[b % 64], 0);

      // Back-pressure on the record; next job's word must wait
      topReady = 1'b0;
      b = n_rec;
      job_q.push_back(2);
      job_q.push_back(1);
      tx_q.push_back(mk(0, 1, 100));
      tx_q.push_back(mk(0, 2, 200));
      tx_q.push_back(mk(0, 3, 300));
      wait_top(30);
      repeat (10) begin
         step();
         check("bp_hold_valid", topValid, 1);
         check("bp_hold_sum", topSum, 300);
         check("bp_no_consume", tx_q.size(), 1);
      end
      topReady = 1'b1;
      wait_recs(2, 30);
      check("bp_first_sum", rec_sum[b % 64], 300);
      check("bp_second_sum", rec_sum[(b + 1) % 64], 300);
      check("bp_second_pcoeff", rec_pc[(b + 1) % 64], 3);

      // ECC on word 2, then a zero-count job, then a one-word job
      b = n_rec;
      job_q.push_back(2);
      job_q.push_back(0);
      job_q.push_back(1);
      tx_q.push_back(mk(0, 1, 10));
      tx_q.push_back(mk(1, 2, 20));
      tx_q.push_back(mk(0, 4, 5));
      wait_recs(3, 60);
      check("ecc_first_ecc", rec_ecc[b % 64], 1);
      check("ecc_first_sum", rec_sum[b % 64], 30);
      check("zero_sum", rec_sum[(b + 1) % 64], 0);
      check("zero_pcoeff", rec_pc[(b + 1) % 64], 0);
      check("zero_ecc", rec_ecc[(b + 1) % 64], 0);
      check("zero_ovf", rec_ovf[(b + 1) % 64], 0);
      check("third_sum", rec_sum[(b + 2) % 64], 5);
      check("third_pcoeff", rec_pc[(b + 2) % 64], 4);
      check("third_ecc", rec_ecc[(b + 2) % 64], 0);

      // Zero-count job timing: push, pop next edge, record one cycle later
      topReady = 1'b0;
      job_q.push_back(0);
      step();
      check("zero_lat_pushed", topValid, 0);
      step();
      check("zero_lat_emit", topValid, 1);
      check("zero_lat_sum", topSum, 0);
      topReady = 1'b1;
      step();

      // FIFO full while blocked in EMIT
      topReady = 1'b0;
      job_q.push_back(1);
      tx_q.push_back(mk(0, 1, 1));
      wait_top(30);
      repeat (5) job_q.push_back(2);
      repeat (4) step();
      check("full_jready", jobReady, 0);
      check("full_fifth_waiting", job_q.size(), 1);
      step();
      check("full_fifth_held", job_q.size(), 1);
      topReady = 1'b1;
      step();
      check("pop_cycle_jready", jobReady, 0);
      step();
      check("after_pop_jready", jobReady, 1);
      step();
      check("fifth_pushed", job_q.size(), 0);
      repeat (10) tx_q.push_back(rand_word());
      wait_recs(5, 80);

      // Wrap and carry-out on both accumulators
      b = n_rec;
      job_q.push_back(2);
      tx_q.push_back(mk(0, 0, 48'hFFFF_FFFF_FFFF));
      tx_q.push_back(mk(0, 0, 48'hFFFF_FFFF_FFFF));
      job_q.push_back(2);
      tx_q.push_back(mk(0, 13'h1FFF, 0));
      tx_q.push_back(mk(0, 13'h1FFF, 0));
      wait_recs(2, 40);
      check("wrap_sum", rec_sum[b % 64], 64'hFFFF_FFFF_FFFE);
      check("wrap_sum_ovf", rec_ovf[b % 64], 1);
      check("wrap_pcoeff", rec_pc[(b + 1) % 64], 64'h1FFE);
      check("wrap_pcoeff_ovf", rec_ovf[(b + 1) % 64], 1);

      // Randomized traffic with random valid/ready throttling
      for (int j = 0; j < 120; j++) begin
         int c;
         c = $urandom_range(0, 6);
         job_q.push_back(c);
         for (int w = 0; w < c; w++) tx_q.push_back(rand_word());
      end
      target = n_rec + 120;
      k      = 0;
      while (n_rec < target && k < 20000) begin
         jv_en    = ($urandom_range(0, 3) != 0);
         rv_en    = ($urandom_range(0, 3) != 0);
         topReady = ($urandom_range(0, 2) != 0);
         step();
         k++;
      end
      check("random_records", n_rec, target);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
